// File: rtl/mem_access_pkg.sv
// Shared widths, state encoding and SRAM level constants for the MEM-stage SRAM responder.
package mem_access_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_REGA_W = 4;

    localparam logic [MEM_DATA_W-1:0] ZeroWord = '0;
    localparam logic [MEM_REGA_W-1:0] RegZero  = '0;

    // SRAM control pins are active low
    localparam logic SRAM_ON  = 1'b0;
    localparam logic SRAM_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_access_wait_cnt.sv
// Loadable wait-cycle counter; tc flags that the count has reached the programmed last value.
module mem_wait_cnt #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/mem_access.sv
// MEM-stage responder: runs loads/stores on an async SRAM and stalls the pipeline until done.
// Optional MEM_ERR_CHECK_EN adds a sticky err_o for conflicting or out-of-range requests.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int REGA_W     = MEM_REGA_W,
    parameter int RAM_ADDR_W = 18,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     memAddr_i,
    input  logic                  rMem_i,
    input  logic                  wMem_i,
    input  logic [DATA_W-1:0]     wData_i,
    input  logic                  wReg_i,
    input  logic [REGA_W-1:0]     wRegAddr_i,
    output logic [DATA_W-1:0]     wData_o,
    output logic                  wReg_o,
    output logic [REGA_W-1:0]     wRegAddr_o,
    output logic                  stallreq_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0]     ram_data_o,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic                  ram_data_oe,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
`ifdef MEM_ERR_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    localparam int CNT_W = cnt_width((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              wr_q;
    logic              cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0]  cnt_last;

    mem_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .last (cnt_last),
        .tc   (cnt_tc)
    );

    // Store wins when both requests are raised together
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_last  = CNT_W'(RD_WAIT - 1);
        case (state)
            IDLE: begin
                if (wMem_i) begin
                    state_nxt = WRITE;
                    cnt_load  = 1'b1;
                end else if (rMem_i) begin
                    state_nxt = READ;
                    cnt_load  = 1'b1;
                end
            end
            READ: begin
                cnt_en = 1'b1;
                if (cnt_tc) state_nxt = DONE;
            end
            WRITE: begin
                cnt_last = CNT_W'(WR_WAIT - 1);
                cnt_en   = 1'b1;
                if (cnt_tc) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= DATA_W'(ZeroWord);
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE) begin
                addr_q  <= memAddr_i;
                wdata_q <= wData_i;
                wr_q    <= wMem_i;
            end
            if (state == READ && cnt_tc)
                rdata_q <= ram_data_i;
        end
    end

    // DONE after a write keeps ce_n and the data drivers on so the SRAM sees data held past we_n rising
    logic done_wr;
    assign done_wr     = (state == DONE) && wr_q;
    assign ram_ce_n    = (state == READ || state == WRITE || done_wr) ? SRAM_ON : SRAM_OFF;
    assign ram_oe_n    = (state == READ)  ? SRAM_ON : SRAM_OFF;
    assign ram_we_n    = (state == WRITE) ? SRAM_ON : SRAM_OFF;
    assign ram_data_oe = (state == WRITE) || done_wr;
    assign ram_addr_o  = RAM_ADDR_W'(addr_q);
    assign ram_data_o  = wdata_q;

    assign stallreq_o = ((state == IDLE) && (rMem_i || wMem_i)) || state == READ || state == WRITE;
    assign wData_o    = ((state == DONE) && !wr_q) ? rdata_q : wData_i;
    assign wReg_o     = wReg_i;
    assign wRegAddr_o = wRegAddr_i;

`ifdef MEM_ERR_CHECK_EN
    logic addr_oor, err_q;

    generate
        if (RAM_ADDR_W < ADDR_W) begin : g_oor
            assign addr_oor = |memAddr_i[ADDR_W-1:RAM_ADDR_W];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (state == IDLE && ((rMem_i && wMem_i) || addr_oor))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`endif

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage responder for the EX/MEM pipeline register outputs (memAddr, rMem, wMem, wData, wReg, wRegAddr).
- Executes loads and stores against the external asynchronous SRAM.
- Holds the pipeline through stallreq_o until the access completes.
- Presents the write-back bundle to the MEM/WB register.
- Non-memory instructions pass through combinationally with zero latency.

Parameters:
- DATA_W, 16, data/register width (RegBus)
- ADDR_W, 16, CPU memory address width (MemAddrBus)
- REGA_W, 4, register address width (RegAddrBus)
- RAM_ADDR_W, 18, SRAM address pins; upper bits driven 0
- RD_WAIT, 2, cycles oe_n held low before read data is sampled (>=1)
- WR_WAIT, 2, cycles we_n held low per write (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- memAddr_i  in  ADDR_W  access address from EX/MEM
- rMem_i  in  1  load request
- wMem_i  in  1  store request
- wData_i  in  DATA_W  ALU result / store data
- wReg_i  in  1  register write enable
- wRegAddr_i  in  REGA_W  destination register
- wData_o  out  DATA_W  write-back data to MEM/WB
- wReg_o  out  1  write-back enable
- wRegAddr_o  out  REGA_W  write-back register
- stallreq_o  out  1  pipeline stall request to stall controller
- ram_addr_o  out  RAM_ADDR_W  SRAM address
- ram_data_o  out  DATA_W  SRAM write data
- ram_data_i  in  DATA_W  SRAM read data
- ram_data_oe  out  1  tri-state enable for the data bus at top level
- ram_ce_n  out  1  chip enable, active low
- ram_oe_n  out  1  output enable, active low
- ram_we_n  out  1  write enable, active low

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, rdata=0.
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_data_oe=0, ram_addr_o=0, ram_data_o=0.
  - Combinational outputs follow the IDLE rules.
- Reset mid-access aborts the access immediately. Controls go inactive the same instant; no partial write is retried.
- States and transitions:
  - IDLE -> WRITE if wMem_i (wins over rMem_i when both are set).
  - IDLE -> READ if rMem_i only.
  - IDLE holds otherwise.
  - On the IDLE exit edge: latch addr, wdata, cnt=0.
  - READ: ce_n=0, oe_n=0. cnt counts 0..RD_WAIT-1. On the edge ending cnt=RD_WAIT-1: rdata<=ram_data_i, -> DONE.
  - WRITE: ce_n=0, we_n=0, ram_data_oe=1. cnt counts 0..WR_WAIT-1, then -> DONE.
  - DONE: one cycle, always -> IDLE; inputs are ignored. After a write: we_n=1, ce_n=0, ram_data_oe=1 (data hold). After a read: all controls inactive.
- stallreq_o = (IDLE & (rMem_i|wMem_i)) | READ | WRITE, combinational. EX/MEM holds its inputs throughout.
- Stall length: load = 1+RD_WAIT cycles, store = 1+WR_WAIT cycles. In DONE the pipeline advances; the next memory op is recognised in IDLE on the following cycle.
- wData_o = rdata when in DONE after a READ, else wData_i.
- wReg_o = wReg_i and wRegAddr_o = wRegAddr_i, always pass-through.
- ram_addr_o = zero-extended latched address; ram_data_o = latched wData_i.
- Address wrap-around and range are not checked by default.

Optional Feature:
- MEM_ERR_CHECK_EN defined:
  - Adds output err_o (1 bit, sticky, cleared only by reset).
  - Set on an IDLE cycle with rMem_i&wMem_i both 1, or memAddr_i >= 2**(RAM_ADDR_W) (only when RAM_ADDR_W < ADDR_W).
  - Access behaviour is unchanged.
- Undefined: no err_o port, no check logic.

Decomposition:
- Shared defines/package: DATA_W/ADDR_W/REGA_W widths, ZeroWord, RegZero, state encodings (IDLE=2'd0, READ=1, WRITE=2, DONE=3), active-low SRAM level constants.
- One natural sub-module: mem_wait_cnt, a loadable wait-cycle counter with a terminal-count flag, shared by READ and WRITE.

Test Plan:
- ALU op passthrough: wData_i=16'h1234, wReg_i=1, wRegAddr_i=3, rMem=wMem=0 -> same cycle wData_o=1234, wReg_o=1, wRegAddr_o=3; stallreq_o=0; ce_n=1.
- Load, RD_WAIT=2: rMem_i=1, memAddr_i=16'h8010, SRAM returns 16'hBEEF -> stallreq_o high 3 cycles; ram_addr_o=18'h08010; oe_n low 2 cycles; DONE wData_o=BEEF.
- Store, WR_WAIT=2: wMem_i=1, addr 16'h0042, wData_i=16'hA5A5 -> we_n low exactly 2 cycles; ram_data_oe high 3 cycles; data=A5A5 whole window; stall 3 cycles.
- Back-to-back load then store -> one DONE cycle between them; second access starts in IDLE next cycle; the first load is not replayed.
- Reset asserted in READ cnt=1 -> within the same cycle ce_n=oe_n=1, stallreq_o=0; after release, state=IDLE.
- MEM_ERR_CHECK_EN: rMem_i=wMem_i=1 -> a write is performed and err_o=1, remaining 1 until rst=0.
